inst_mem_loader: RTL and testbench
==================================

// Module: inst_mem_loader
// PURPOSE
//  Synthesizable program loader for the MIPS pipeline; replaces hand-driven instruction loading.
//  Accepts a byte stream (from the debug UART), assembles NB_DATA-bit instruction words MSB-first,
//  and writes them to consecutive instruction-memory addresses starting at 0.
//  Holds the pipeline in debug/load mode until a HALT word is written, then releases it.
//  Sits between the debug unit's receive path and the pipeline's i_inst_load/i_addr_inst_load/i_en_write ports.
// PARAMETERS
//  NB_DATA      32        instruction word width; must be a multiple of NB_BYTE
//  NB_BYTE      8         width of one stream element
//  ADDRWIDTH    7         instruction-memory address width (word addressed)
//  HALT_OPCODE  6'h3F     opcode field [NB_DATA-1 -: 6] that ends loading
// PORTS
//  clock         in   1          system clock
//  i_reset       in   1          asynchronous reset, active-high
//  i_start       in   1          one-cycle pulse: begin a load (ignored unless IDLE or DONE)
//  i_abort       in   1          cancel load; return to IDLE; next write starts at address 0
//  i_rx_valid    in   1          i_rx_byte is valid this cycle
//  i_rx_byte     in   NB_BYTE    stream element
//  o_rx_ready    out  1          loader accepts a byte this cycle (valid & ready = transfer)
//  o_inst_load   out  NB_DATA    assembled instruction
//  o_addr_load   out  ADDRWIDTH  write address
//  o_en_write    out  1          one-cycle instruction-memory write strobe
//  o_debug_unit  out  1          high while loading (pipeline held in load mode)
//  o_done        out  1          level: HALT written, program ready; cleared by i_start/i_abort
//  o_error       out  1          level: memory full before HALT; cleared by i_start/i_abort
//  o_word_count  out  ADDRWIDTH+1  words written in current/last load
// BEHAVIOUR
//  Reset: state IDLE, all outputs 0, byte counter 0, address 0.
//  FSM: IDLE -i_start-> RECV; RECV -last byte of word accepted-> WRITE; WRITE -> RECV,
//   or DONE (word is HALT), or ERROR (address was 2**ADDRWIDTH-1 and word not HALT).
//   DONE/ERROR -i_start-> RECV (address and count reset to 0). Any state -i_abort-> IDLE.
//  o_rx_ready = 1 only in RECV. No bytes accepted in WRITE/DONE/ERROR/IDLE.
//  Assembly: shift register, first byte -> bits [NB_DATA-1 -: NB_BYTE]; NB_DATA/NB_BYTE bytes per word.
//  Latency: last byte accepted on edge N -> o_en_write=1 during cycle N..N+1 with stable
//   o_inst_load/o_addr_load; address and o_word_count increment on edge N+1.
//  o_en_write is exactly one cycle per word; never asserted outside WRITE.
//  o_debug_unit = 1 in RECV and WRITE; 0 in IDLE, DONE, ERROR (releases pipeline after HALT write).
//  HALT check on opcode field only; HALT word itself is written and counted.
//  Full memory: HALT at last address -> DONE (not ERROR); address never wraps.
//  i_abort and i_start same cycle: abort wins. i_abort during WRITE: write strobe suppressed.
//  i_start while RECV/WRITE: ignored. Reset mid-load: everything to reset values immediately.
//  Partial word (bytes left over) on i_abort discarded.
// STRUCTURE
//  Shared package/header (parameters.vh): ADDRWIDTH, HALT opcode, FSM state encodings.
//  One natural sub-module: word_assembler (shift reg + byte counter, o_word_valid pulse).
//  FSM, address counter and strobe generation in the top module.
// TESTING
//  1. Reset, i_start, stream 0x3C,0x01,0x00,0x0A -> one o_en_write, addr 0, inst 0x3C01000A, count 1.
//  2. 3 words then 0xFC000000 -> writes at addr 0..3, o_done=1, o_debug_unit=0 after 4th write, count 4.
//  3. Gaps in i_rx_valid between bytes -> same words/addresses as case 2; no extra strobes.
//  4. ADDRWIDTH=2, 4 non-HALT words -> 4 writes, o_error=1, 5th word bytes not accepted (ready=0).
//  5. i_abort after 2 bytes of word 1 -> IDLE, no write; i_start then full word -> written at addr 0.
//  6. i_reset asserted mid-word -> outputs 0 asynchronously; HALT at last address (ADDRWIDTH=2) -> o_done, not o_error.

Source files
------------

// File: rtl/inst_mem_loader_pkg.sv
// Shared definitions for the instruction-memory program loader.
// Holds the default geometry, the HALT opcode and the FSM state encoding.
package inst_mem_loader_pkg;

   localparam int          NB_DATA_DEF     = 32;
   localparam int          NB_BYTE_DEF     = 8;
   localparam int          ADDRWIDTH_DEF   = 7;
   localparam int          NB_OPCODE       = 6;
   localparam logic [5:0]  HALT_OPCODE_DEF = 6'h3F;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RECV  = 3'd1,
      ST_WRITE = 3'd2,
      ST_DONE  = 3'd3,
      ST_ERROR = 3'd4
   } state_t;

   function automatic logic is_halt(input logic [NB_OPCODE-1:0] opcode,
                                    input logic [NB_OPCODE-1:0] halt_op);
      return opcode == halt_op;
   endfunction

endpackage

// File: rtl/inst_mem_loader_word_assembler.sv
// Packs the incoming byte stream MSB-first into instruction words.
// o_word_valid flags the cycle whose accepted byte completes a word.
module inst_mem_loader_word_assembler #(
   parameter int NB_DATA = 32,
   parameter int NB_BYTE = 8
) (
   input  logic               clock,
   input  logic               i_reset,
   input  logic               i_clear,
   input  logic               i_accept,
   input  logic [NB_BYTE-1:0] i_byte,
   output logic [NB_DATA-1:0] o_word,
   output logic               o_word_valid
);

   localparam int NB_WORD_BYTES = NB_DATA / NB_BYTE;
   localparam int CNT_W         = (NB_WORD_BYTES > 1) ? $clog2(NB_WORD_BYTES) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NB_WORD_BYTES - 1);

   logic [NB_DATA-1:0] word_q;
   logic [CNT_W-1:0]   cnt_q;

   assign o_word       = word_q;
   assign o_word_valid = i_accept && !i_clear && (cnt_q == LAST_CNT);

   always_ff @(posedge clock or posedge i_reset) begin
      if (i_reset) begin
         word_q <= '0;
         cnt_q  <= '0;
      end else if (i_clear) begin
         word_q <= '0;
         cnt_q  <= '0;
      end else if (i_accept) begin
         word_q <= {word_q[NB_DATA-NB_BYTE-1:0], i_byte};
         cnt_q  <= (cnt_q == LAST_CNT) ? '0 : cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/inst_mem_loader.sv
// Program loader: byte stream -> instruction-memory writes from address 0 until a HALT word.
// state    | meaning
// IDLE     | waiting for i_start, pipeline free
// RECV     | accepting bytes of the next word, pipeline held
// WRITE    | one-cycle write strobe for the assembled word
// DONE     | HALT written, program ready, pipeline released
// ERROR    | memory filled without HALT, pipeline released
module inst_mem_loader
   import inst_mem_loader_pkg::*;
#(
   parameter int         NB_DATA     = NB_DATA_DEF,
   parameter int         NB_BYTE     = NB_BYTE_DEF,
   parameter int         ADDRWIDTH   = ADDRWIDTH_DEF,
   parameter logic [5:0] HALT_OPCODE = HALT_OPCODE_DEF
) (
   input  logic                 clock,
   input  logic                 i_reset,
   input  logic                 i_start,
   input  logic                 i_abort,
   input  logic                 i_rx_valid,
   input  logic [NB_BYTE-1:0]   i_rx_byte,
   output logic                 o_rx_ready,
   output logic [NB_DATA-1:0]   o_inst_load,
   output logic [ADDRWIDTH-1:0] o_addr_load,
   output logic                 o_en_write,
   output logic                 o_debug_unit,
   output logic                 o_done,
   output logic                 o_error,
   output logic [ADDRWIDTH:0]   o_word_count
);

   localparam logic [ADDRWIDTH-1:0] ADDR_MAX = '1;

   state_t                state_q;
   logic [ADDRWIDTH-1:0]  addr_q;
   logic [ADDRWIDTH:0]    count_q;
   logic [NB_DATA-1:0]    word;
   logic                  word_valid;
   logic                  can_start;
   logic                  asm_clear;
   logic                  halt_word;

   assign can_start  = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERROR);
   assign asm_clear  = i_abort || (i_start && can_start);
   assign halt_word  = is_halt(word[NB_DATA-1 -: NB_OPCODE], HALT_OPCODE);

   assign o_rx_ready   = (state_q == ST_RECV);
   assign o_debug_unit = (state_q == ST_RECV) || (state_q == ST_WRITE);
   assign o_done       = (state_q == ST_DONE);
   assign o_error      = (state_q == ST_ERROR);
   // An abort landing in the WRITE cycle must not leave a stray word in memory.
   assign o_en_write   = (state_q == ST_WRITE) && !i_abort;
   assign o_inst_load  = word;
   assign o_addr_load  = addr_q;
   assign o_word_count = count_q;

   inst_mem_loader_word_assembler #(
      .NB_DATA (NB_DATA),
      .NB_BYTE (NB_BYTE)
   ) u_word_assembler (
      .clock        (clock),
      .i_reset      (i_reset),
      .i_clear      (asm_clear),
      .i_accept     (i_rx_valid && o_rx_ready),
      .i_byte       (i_rx_byte),
      .o_word       (word),
      .o_word_valid (word_valid)
   );

   always_ff @(posedge clock or posedge i_reset) begin
      if (i_reset) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         count_q <= '0;
      end else if (i_abort) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
               if (i_start) begin
                  state_q <= ST_RECV;
                  addr_q  <= '0;
                  count_q <= '0;
               end
            end
            ST_RECV: begin
               if (word_valid) state_q <= ST_WRITE;
            end
            ST_WRITE: begin
               count_q <= count_q + 1'b1;
               // Address saturates at the top so a full memory never wraps onto word 0.
               if (addr_q != ADDR_MAX) addr_q <= addr_q + 1'b1;
               if (halt_word)              state_q <= ST_DONE;
               else if (addr_q == ADDR_MAX) state_q <= ST_ERROR;
               else                         state_q <= ST_RECV;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Scoreboard bench for inst_mem_loader with a 4-word memory (ADDRWIDTH=2).
module tb_inst_mem_loader;

   typedef struct {
      logic [1:0]  addr;
      logic [31:0] inst;
   } exp_t;

   logic        clock = 1'b0;
   logic        i_reset;
   logic        i_start;
   logic        i_abort;
   logic        i_rx_valid;
   logic [7:0]  i_rx_byte;
   logic        o_rx_ready;
   logic [31:0] o_inst_load;
   logic [1:0]  o_addr_load;
   logic        o_en_write;
   logic        o_debug_unit;
   logic        o_done;
   logic        o_error;
   logic [2:0]  o_word_count;

   int   checks   = 0;
   int   failures = 0;
   int   n_writes = 0;
   exp_t exp_q[$];

   always #5 clock = ~clock;

   inst_mem_loader #(
      .NB_DATA     (32),
      .NB_BYTE     (8),
      .ADDRWIDTH   (2),
      .HALT_OPCODE (6'h3F)
   ) dut (
      .clock        (clock),
      .i_reset      (i_reset),
      .i_start      (i_start),
      .i_abort      (i_abort),
      .i_rx_valid   (i_rx_valid),
      .i_rx_byte    (i_rx_byte),
      .o_rx_ready   (o_rx_ready),
      .o_inst_load  (o_inst_load),
      .o_addr_load  (o_addr_load),
      .o_en_write   (o_en_write),
      .o_debug_unit (o_debug_unit),
      .o_done       (o_done),
      .o_error      (o_error),
      .o_word_count (o_word_count)
   );

   // Write monitor: every strobe must match the oldest expected word.
   always @(negedge clock) begin
      if (o_en_write) begin
         n_writes++;
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL write_unexpected: addr=%0d inst=%h, none expected", o_addr_load, o_inst_load);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (o_addr_load !== e.addr || o_inst_load !== e.inst) begin
               failures++;
               $display("FAIL write_data: got addr=%0d inst=%h, want addr=%0d inst=%h",
                        o_addr_load, o_inst_load, e.addr, e.inst);
            end
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic pulse_start();
      @(posedge clock); #1 i_start = 1'b1;
      @(posedge clock); #1 i_start = 1'b0;
   endtask

   task automatic pulse_abort();
      @(posedge clock); #1 i_abort = 1'b1;
      @(posedge clock); #1 i_abort = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int t = 0;
      i_rx_valid = 1'b1;
      i_rx_byte  = b;
      @(negedge clock);
      while (!o_rx_ready && t < 50) begin
         @(negedge clock);
         t++;
      end
      if (!o_rx_ready) begin
         checks++;
         failures++;
         $display("FAIL byte_timeout: ready=%b after %0d cycles, want 1", o_rx_ready, t);
      end else begin
         @(posedge clock);
      end
      #1 i_rx_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input logic [1:0] addr, input int max_gap);
      exp_t e;
      e.addr = addr;
      e.inst = w;
      exp_q.push_back(e);
      for (int i = 3; i >= 0; i--) begin
         send_byte(w[i*8 +: 8]);
         if (max_gap > 0) cycles($urandom_range(max_gap, 0));
      end
   endtask

   task automatic check_status(input string name, input logic done, input logic err,
                               input logic dbg, input logic [2:0] cnt);
      checks++;
      if (o_done !== done || o_error !== err || o_debug_unit !== dbg || o_word_count !== cnt) begin
         failures++;
         $display("FAIL %s: done=%b err=%b dbg=%b cnt=%0d, want done=%b err=%b dbg=%b cnt=%0d",
                  name, o_done, o_error, o_debug_unit, o_word_count, done, err, dbg, cnt);
      end
   endtask

   task automatic test_reset();
      i_reset = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_rx_valid = 1'b0; i_rx_byte = '0;
      cycles(3);
      checks++;
      if ({o_rx_ready, o_en_write, o_debug_unit, o_done, o_error} !== 5'b0 ||
          o_inst_load !== 32'h0 || o_addr_load !== 2'd0 || o_word_count !== 3'd0) begin
         failures++;
         $display("FAIL reset_outputs: rdy=%b wr=%b dbg=%b done=%b err=%b inst=%h addr=%0d cnt=%0d, want all 0",
                  o_rx_ready, o_en_write, o_debug_unit, o_done, o_error, o_inst_load, o_addr_load, o_word_count);
      end
      @(negedge clock) i_reset = 1'b0;
      cycles(2);
   endtask

   task automatic test_single_word();
      pulse_start();
      checks++;
      if (o_rx_ready !== 1'b1) begin
         failures++;
         $display("FAIL start_ready: ready=%b, want 1", o_rx_ready);
      end
      send_word(32'h3C01000A, 2'd0, 0);
      cycles(3);
      check_status("single_word", 1'b0, 1'b0, 1'b1, 3'd1);
      checks++;
      if (n_writes !== 1 || exp_q.size() != 0) begin
         failures++;
         $display("FAIL single_word_writes: writes=%0d pending=%0d, want 1 and 0", n_writes, exp_q.size());
      end
      pulse_abort();
   endtask

   task automatic test_halt_program(input int max_gap, input string name);
      int w0 = n_writes;
      pulse_start();
      check_status({name, "_start"}, 1'b0, 1'b0, 1'b1, 3'd0);
      send_word(32'h11111111, 2'd0, max_gap);
      pulse_start();
      send_word(32'h22222222, 2'd1, max_gap);
      send_word(32'h33333333, 2'd2, max_gap);
      send_word(32'hFC000000, 2'd3, max_gap);
      cycles(2);
      check_status(name, 1'b1, 1'b0, 1'b0, 3'd4);
      checks++;
      if (n_writes - w0 != 4 || exp_q.size() != 0 || o_rx_ready !== 1'b0) begin
         failures++;
         $display("FAIL %s_writes: writes=%0d pending=%0d ready=%b, want 4 0 0",
                  name, n_writes - w0, exp_q.size(), o_rx_ready);
      end
   endtask

   task automatic test_full_error();
      int w0 = n_writes;
      int seen_ready = 0;
      pulse_start();
      send_word(32'h00000001, 2'd0, 0);
      send_word(32'h20080005, 2'd1, 1);
      send_word(32'hF8000000, 2'd2, 0);
      send_word(32'h7C00FFFF, 2'd3, 0);
      cycles(2);
      check_status("full_error", 1'b0, 1'b1, 1'b0, 3'd4);
      i_rx_valid = 1'b1;
      i_rx_byte  = 8'hAB;
      repeat (10) begin
         @(negedge clock);
         if (o_rx_ready) seen_ready++;
      end
      #1 i_rx_valid = 1'b0;
      checks++;
      if (seen_ready != 0 || n_writes - w0 != 4) begin
         failures++;
         $display("FAIL full_no_accept: ready_cycles=%0d writes=%0d, want 0 and 4", seen_ready, n_writes - w0);
      end
      pulse_abort();
      check_status("error_cleared", 1'b0, 1'b0, 1'b0, 3'd4);
   endtask

   task automatic test_abort();
      int w0 = n_writes;
      pulse_start();
      send_byte(8'hDE);
      send_byte(8'hAD);
      pulse_abort();
      checks++;
      if (o_debug_unit !== 1'b0 || o_rx_ready !== 1'b0 || n_writes != w0) begin
         failures++;
         $display("FAIL abort_partial: dbg=%b ready=%b writes=%0d, want 0 0 0", o_debug_unit, o_rx_ready, n_writes - w0);
      end
      pulse_start();
      send_word(32'h8C020004, 2'd0, 0);
      cycles(2);
      check_status("after_abort", 1'b0, 1'b0, 1'b1, 3'd1);
      send_byte(8'h01);
      send_byte(8'h02);
      send_byte(8'h03);
      send_byte(8'h04);
      i_abort = 1'b1;
      @(posedge clock); #1 i_abort = 1'b0;
      cycles(2);
      checks++;
      if (n_writes - w0 != 1 || exp_q.size() != 0 || o_debug_unit !== 1'b0) begin
         failures++;
         $display("FAIL abort_in_write: writes=%0d pending=%0d dbg=%b, want 1 0 0",
                  n_writes - w0, exp_q.size(), o_debug_unit);
      end
   endtask

   task automatic test_abort_start_same_cycle();
      test_halt_program(0, "pre_collide");
      @(posedge clock); #1 begin i_start = 1'b1; i_abort = 1'b1; end
      @(posedge clock); #1 begin i_start = 1'b0; i_abort = 1'b0; end
      check_status("abort_beats_start", 1'b0, 1'b0, 1'b0, 3'd4);
   endtask

   task automatic test_reset_mid();
      pulse_start();
      send_byte(8'h12);
      send_byte(8'h34);
      #1 i_reset = 1'b1;
      #1;
      checks++;
      if ({o_rx_ready, o_debug_unit, o_en_write} !== 3'b0 || o_inst_load !== 32'h0 ||
          o_word_count !== 3'd0) begin
         failures++;
         $display("FAIL reset_async: rdy=%b dbg=%b wr=%b inst=%h cnt=%0d, want all 0",
                  o_rx_ready, o_debug_unit, o_en_write, o_inst_load, o_word_count);
      end
      @(negedge clock) i_reset = 1'b0;
      cycles(1);
      test_halt_program(0, "halt_after_reset");
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_halt_program(0, "halt_last_addr");
      test_halt_program(3, "gaps");
      test_full_error();
      test_abort();
      test_abort_start_same_cycle();
      test_reset_mid();
      cycles(2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
